// File: rtl/fu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fu_operand_stage_if
// Brief    : Instruction, fu result, execute-operand and debug bus of the
//            fu operand stage.
// Revision : 1.0
// ============================================================================
interface fu_operand_stage_if #(
    parameter int DW    = 16,
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);

    logic          instr_valid_in;
    logic          instr_ready_out;
    logic [AW-1:0] da_in;
    logic [AW-1:0] aa_in;
    logic [AW-1:0] ba_in;
    logic [3:0]    op_fs_in;
    logic          mb_in;
    logic [DW-1:0] const_in;
    logic          rw_in;
    logic          hold_in;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [3:0]    fs_out;
    logic          valid_out;
    logic [DW-1:0] f_in;
    logic          z_in;
    logic          n_in;
    logic          z_flag_out;
    logic          n_flag_out;
    logic [AW-1:0] dbg_addr_in;
    logic [DW-1:0] dbg_data_out;

    modport master (
        output instr_valid_in, da_in, aa_in, ba_in, op_fs_in, mb_in,
               const_in, rw_in, hold_in, f_in, z_in, n_in, dbg_addr_in,
        input  instr_ready_out, a_out, b_out, fs_out, valid_out,
               z_flag_out, n_flag_out, dbg_data_out
    );

    modport slave (
        input  instr_valid_in, da_in, aa_in, ba_in, op_fs_in, mb_in,
               const_in, rw_in, hold_in, f_in, z_in, n_in, dbg_addr_in,
        output instr_ready_out, a_out, b_out, fs_out, valid_out,
               z_flag_out, n_flag_out, dbg_data_out
    );
endinterface
`default_nettype wire

// File: rtl/fu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : fu_operand_stage
// Brief    : Register file, operand fetch with write-back bypass, and
//            result/flag capture in front of the fu function unit.
// Revision : 1.0
// ============================================================================
module fu_operand_stage #(
    parameter int DW    = 16,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  wire              clk,
    input  wire              rst,
    fu_operand_stage_if.slave bus
);

    logic [DW-1:0] r_regs [NREGS];
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [3:0]    r_fs;
    logic          r_valid;
    logic [AW-1:0] r_ex_da;
    logic          r_ex_rw;
    logic          r_z_flag;
    logic          r_n_flag;

    logic          w_retire;
    logic          w_wr;
    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;

    assign w_retire = r_valid & ~bus.hold_in;
    assign w_wr     = w_retire & r_ex_rw;

    // A result retiring this edge must be seen by the instruction loaded on it.
    always_comb begin
        w_rd_a = r_regs[bus.aa_in];
        if (w_wr && (r_ex_da == bus.aa_in))
            w_rd_a = bus.f_in;

        w_rd_b = r_regs[bus.ba_in];
        if (bus.mb_in)
            w_rd_b = bus.const_in;
        else if (w_wr && (r_ex_da == bus.ba_in))
            w_rd_b = bus.f_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[r_ex_da] <= bus.f_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_fs    <= '0;
            r_valid <= 1'b0;
            r_ex_da <= '0;
            r_ex_rw <= 1'b0;
        end else if (!bus.hold_in) begin
            r_valid <= bus.instr_valid_in;
            if (bus.instr_valid_in) begin
                r_a     <= w_rd_a;
                r_b     <= w_rd_b;
                r_fs    <= bus.op_fs_in;
                r_ex_da <= bus.da_in;
                r_ex_rw <= bus.rw_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_z_flag <= 1'b0;
            r_n_flag <= 1'b0;
        end else if (w_retire) begin
            r_z_flag <= bus.z_in;
            r_n_flag <= bus.n_in;
        end
    end

    assign bus.instr_ready_out = ~bus.hold_in;
    assign bus.a_out           = r_a;
    assign bus.b_out           = r_b;
    assign bus.fs_out          = r_fs;
    assign bus.valid_out       = r_valid;
    assign bus.z_flag_out      = r_z_flag;
    assign bus.n_flag_out      = r_n_flag;
    assign bus.dbg_data_out    = r_regs[bus.dbg_addr_in];

endmodule
`default_nettype wire

// File: tb/tb_fu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_operand_stage
// Brief    : Directed bench for fu_operand_stage against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_fu_operand_stage;
    localparam int c_DW    = 16;
    localparam int c_NREGS = 8;

    logic clk;
    logic rst;
    logic echo;
    logic [15:0] f_drv;
    logic armed;
    int checks;
    int errors;

    fu_operand_stage_if #(.DW(c_DW), .NREGS(c_NREGS)) bus ();

    fu_operand_stage #(.DW(c_DW), .NREGS(c_NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fu stand-in: either echo operand B or return a driven value
    assign bus.f_in = echo ? bus.b_out : f_drv;

    // Model state: architectural registers, the instruction in the execute
    // slot, and the status flags.
    logic [15:0] m_regs [8];
    logic [15:0] m_a, m_b;
    logic [3:0]  m_fs;
    logic        m_v;
    logic [2:0]  m_da;
    logic        m_rw;
    logic        m_z, m_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.instr_valid_in = 1'b0;
        bus.da_in          = '0;
        bus.aa_in          = '0;
        bus.ba_in          = '0;
        bus.op_fs_in       = '0;
        bus.mb_in          = 1'b0;
        bus.const_in       = '0;
        bus.rw_in          = 1'b0;
        bus.hold_in        = 1'b0;
        bus.z_in           = 1'b0;
        bus.n_in           = 1'b0;
        echo               = 1'b1;
        f_drv              = '0;
    endtask

    // One clock: the model applies the instruction-level rules at the edge.
    // A retiring result is committed before the new operands are read, so a
    // dependent read sees the fresh value.
    task automatic tick();
        logic [15:0] fval;
        @(posedge clk);
        fval = echo ? m_b : f_drv;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_a = '0; m_b = '0; m_fs = '0; m_v = 1'b0;
            m_da = '0; m_rw = 1'b0; m_z = 1'b0; m_n = 1'b0;
        end else if (!bus.hold_in) begin
            if (m_v) begin
                if (m_rw) m_regs[m_da] = fval;
                m_z = bus.z_in;
                m_n = bus.n_in;
            end
            m_v = bus.instr_valid_in;
            if (bus.instr_valid_in) begin
                m_a  = m_regs[bus.aa_in];
                m_b  = bus.mb_in ? bus.const_in : m_regs[bus.ba_in];
                m_fs = bus.op_fs_in;
                m_da = bus.da_in;
                m_rw = bus.rw_in;
            end
        end
        armed = 1'b1;
        #1;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [15:0] exp, input string name);
        bus.dbg_addr_in = addr;
        #1;
        chk(name, 32'(bus.dbg_data_out), 32'(exp));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("a_out",      32'(bus.a_out),           32'(m_a));
            chk("b_out",      32'(bus.b_out),           32'(m_b));
            chk("fs_out",     32'(bus.fs_out),          32'(m_fs));
            chk("valid_out",  32'(bus.valid_out),       32'(m_v));
            chk("z_flag",     32'(bus.z_flag_out),      32'(m_z));
            chk("n_flag",     32'(bus.n_flag_out),      32'(m_n));
            chk("ready",      32'(bus.instr_ready_out), 32'(!bus.hold_in));
            chk("dbg_data",   32'(bus.dbg_data_out),    32'(m_regs[bus.dbg_addr_in]));
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        idle();
        bus.dbg_addr_in = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "reset_reg");
        chk("reset_valid", 32'(bus.valid_out),       32'd0);
        chk("reset_z",     32'(bus.z_flag_out),      32'd0);
        chk("reset_n",     32'(bus.n_flag_out),      32'd0);
        chk("reset_ready", 32'(bus.instr_ready_out), 32'd1);

        // constant load into R3
        bus.instr_valid_in = 1'b1; bus.da_in = 3'd3; bus.mb_in = 1'b1;
        bus.const_in = 16'h1234; bus.rw_in = 1'b1; bus.op_fs_in = 4'hC;
        tick();
        chk("const_b",     32'(bus.b_out),     32'h1234);
        chk("const_valid", 32'(bus.valid_out), 32'd1);
        chk("const_fs",    32'(bus.fs_out),    32'hC);
        idle();
        tick();
        rd(3'd3, 16'h1234, "const_r3");

        // R3 = 00FF, then a dependent read of R3 on both ports next cycle
        bus.instr_valid_in = 1'b1; bus.da_in = 3'd3; bus.mb_in = 1'b1;
        bus.const_in = 16'h00FF; bus.rw_in = 1'b1;
        tick();
        idle();
        bus.instr_valid_in = 1'b1; bus.aa_in = 3'd3; bus.ba_in = 3'd3;
        bus.mb_in = 1'b0; bus.da_in = 3'd6; bus.rw_in = 1'b0; bus.op_fs_in = 4'h2;
        tick();
        chk("bypass_a", 32'(bus.a_out), 32'h00FF);
        chk("bypass_b", 32'(bus.b_out), 32'h00FF);
        rd(3'd3, 16'h00FF, "bypass_r3");
        idle();
        tick();

        // hold with a live write to R5
        bus.instr_valid_in = 1'b1; bus.da_in = 3'd5; bus.aa_in = 3'd3;
        bus.mb_in = 1'b1; bus.const_in = 16'hBEEF; bus.rw_in = 1'b1;
        tick();
        bus.const_in = 16'h1111; bus.aa_in = 3'd1;
        bus.hold_in = 1'b1; bus.z_in = 1'b1; bus.n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_a",     32'(bus.a_out),           32'h00FF);
            chk("hold_b",     32'(bus.b_out),           32'hBEEF);
            chk("hold_ready", 32'(bus.instr_ready_out), 32'd0);
            chk("hold_z",     32'(bus.z_flag_out),      32'd0);
            rd(3'd5, 16'h0000, "hold_r5");
        end
        idle();
        tick();
        rd(3'd5, 16'hBEEF, "release_r5");
        chk("release_valid", 32'(bus.valid_out), 32'd0);
        bus.z_in = 1'b1; f_drv = 16'h7777; echo = 1'b0;
        tick();
        rd(3'd5, 16'hBEEF, "release_r5_once");
        chk("idle_no_flag", 32'(bus.z_flag_out), 32'd0);
        idle();

        // flags only, no register write
        bus.instr_valid_in = 1'b1; bus.da_in = 3'd1; bus.mb_in = 1'b1;
        bus.const_in = 16'h5555; bus.rw_in = 1'b0;
        tick();
        idle();
        bus.z_in = 1'b1; bus.n_in = 1'b0;
        tick();
        chk("flag_z1", 32'(bus.z_flag_out), 32'd1);
        chk("flag_n0", 32'(bus.n_flag_out), 32'd0);
        rd(3'd1, 16'h0000, "flag_r1");
        bus.instr_valid_in = 1'b1; bus.da_in = 3'd1; bus.rw_in = 1'b0;
        bus.z_in = 1'b0; bus.n_in = 1'b0;
        tick();
        idle();
        bus.z_in = 1'b0; bus.n_in = 1'b1;
        tick();
        chk("flag_z0", 32'(bus.z_flag_out), 32'd0);
        chk("flag_n1", 32'(bus.n_flag_out), 32'd1);
        rd(3'd1, 16'h0000, "flag_r1b");

        // R0 is writable
        bus.instr_valid_in = 1'b1; bus.da_in = 3'd0; bus.mb_in = 1'b1;
        bus.const_in = 16'h5A5A; bus.rw_in = 1'b1;
        tick();
        idle();
        tick();
        rd(3'd0, 16'h5A5A, "r0_write");

        // reset wins over a retiring write
        bus.instr_valid_in = 1'b1; bus.da_in = 3'd2; bus.mb_in = 1'b1;
        bus.const_in = 16'hAAAA; bus.rw_in = 1'b1;
        tick();
        idle();
        echo = 1'b0; f_drv = 16'hAAAA; bus.z_in = 1'b1; bus.n_in = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        rd(3'd2, 16'h0000, "rst_r2");
        rd(3'd3, 16'h0000, "rst_r3");
        chk("rst_valid", 32'(bus.valid_out),  32'd0);
        chk("rst_z",     32'(bus.z_flag_out), 32'd0);
        chk("rst_n",     32'(bus.n_flag_out), 32'd0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fu_operand_stage.md
Name: fu_operand_stage

Overview:
- Operand-fetch and write-back stage directly upstream of the fu function unit.
- Holds the 8x16 general register file. Accepts one decoded micro-instruction per cycle and registers operands A/B plus the function select onto a_out/b_out/fs_out, which drive fu a_in/b_in/fs_in.
- Captures fu's combinational result (f_out, z_out, n_out) back into the destination register and a status-flag register.
- Bypasses a result being written back to a dependent read in the same cycle.

Parameters:
- DW, 16, datapath width; must match fu operand width.
- NREGS, 8, number of general registers; power of two.
- AW, $clog2(NREGS), register address width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid_in  input  1  micro-instruction present this cycle.
- instr_ready_out  output  1  stage can accept; equals ~hold_in.
- da_in  input  AW  destination register address.
- aa_in  input  AW  operand-A source register address.
- ba_in  input  AW  operand-B source register address.
- op_fs_in  input  4  function select, passed to fu unchanged.
- mb_in  input  1  1 = B operand from const_in, 0 = register[ba_in].
- const_in  input  DW  constant operand.
- rw_in  input  1  1 = write result to register[da_in] at retirement.
- hold_in  input  1  downstream stall; freezes execute registers.
- a_out  output  DW  registered operand A, to fu a_in.
- b_out  output  DW  registered operand B, to fu b_in.
- fs_out  output  4  registered function select, to fu fs_in.
- valid_out  output  1  execute slot holds a live instruction.
- f_in  input  DW  fu f_out.
- z_in  input  1  fu z_out.
- n_in  input  1  fu n_out.
- z_flag_out  output  1  registered zero flag.
- n_flag_out  output  1  registered negative flag.
- dbg_addr_in  input  AW  debug read address.
- dbg_data_out  output  DW  combinational register[dbg_addr_in]; no bypass.

Behaviour:
- Reset (rst=1 at edge):
  - all registers R0..R(NREGS-1) = 0
  - a_out = b_out = 0, fs_out = 0, valid_out = 0
  - z_flag_out = n_flag_out = 0
  - reset has priority over every other event, including a write-back in the same cycle.
- Accept: instr_valid_in & instr_ready_out at an edge loads a_out, b_out, fs_out, plus internal ex_da and ex_rw, and sets valid_out=1.
  - Edge with no valid instruction and no hold: valid_out=0; a_out/b_out/fs_out keep their values.
- Operand read is combinational on aa_in/ba_in, then registered. Latency from instruction to fu inputs is exactly 1 cycle.
- Retire: a cycle with valid_out=1 & hold_in=0. At the end of that cycle:
  - if ex_rw=1, register[ex_da] <= f_in
  - always z_flag_out <= z_in and n_flag_out <= n_in
  - exactly one write and one flag update per instruction.
- Hold: hold_in=1 freezes a_out/b_out/fs_out/valid_out/ex_da/ex_rw and suppresses write and flag update. instr_ready_out=0, so the input instruction is not consumed.
- Bypass:
  - If retiring with ex_rw=1 and ex_da==aa_in, the loaded A is f_in instead of the stale register value.
  - Same for ba_in when mb_in=0.
  - mb_in=1 always selects const_in; no bypass.
- R0 is an ordinary writable register; no hardwired zero.
- Register-file write and dbg read of the same address in the same cycle: dbg_data_out shows the old value.
- No arithmetic in this block; widths pass through unmodified.

Test Plan:
- Reset: assert rst 2 cycles, sweep dbg_addr 0..7 -> all 0; valid_out=0, z_flag_out=0, n_flag_out=0, instr_ready_out=1.
- Constant load:
  - Issue da=3, mb=1, const=16'h1234, rw=1, with the bench echoing f_in=b_out.
  - Next cycle b_out=16'h1234 and valid_out=1; one cycle later dbg R3=16'h1234.
- Bypass:
  - Write R3=16'h00FF.
  - Issue aa=3 in the cycle immediately after -> a_out=16'h00FF in the following cycle, not the old R3.
  - Same check for ba=3 with mb=0.
- Hold:
  - Live instruction writing R5=16'hBEEF; hold_in=1 for 3 cycles -> a_out stable, instr_ready_out=0, R5 unchanged.
  - Release -> R5=16'hBEEF after exactly one write.
- Flags only:
  - rw=0 with z_in=1, n_in=0 -> z_flag_out=1, no register changes.
  - Then z_in=0, n_in=1 -> n_flag_out=1, z_flag_out=0.
- Reset mid-operation: rst=1 in a retire cycle with rw=1, da=2, f_in=16'hAAAA -> R2=0, valid_out=0, flags 0.
